// File: rtl/dff_pipe.sv
// Register pipeline with per-stage valids, valid/ready on both ends,
// bubble collapse under backpressure and synchronous flush.
module dff_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] d   [DEPTH];
  logic [WIDTH-1:0] src [DEPTH];
  logic             in_xfer;
  logic             out_xfer;
  logic             go;

  // Ready ripples from the output end back to the input in one cycle.
  always_comb begin
    adv = '0;
    go  = v[DEPTH-1] & out_ready & ~flush;
    adv[DEPTH-1] = go;
    for (int k = DEPTH-2; k >= 0; k--) begin
      go     = v[k] & (~v[k+1] | go);
      adv[k] = go;
    end
  end

  assign in_ready  = (~v[0] | adv[0]) & ~flush;
  assign out_valid = v[DEPTH-1] & ~flush;
  assign out_data  = d[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    load    = '0;
    load[0] = in_xfer;
    src[0]  = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      load[k] = adv[k-1];
      src[k]  = d[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v     <= '0;
      count <= '0;
      for (int k = 0; k < DEPTH; k++) d[k] <= RESET_VAL;
    end else if (flush) begin
      v     <= '0;
      count <= '0;
      for (int k = 0; k < DEPTH; k++) d[k] <= RESET_VAL;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (load[k]) begin
          v[k] <= 1'b1;
          d[k] <= src[k];
        end else if (adv[k]) begin
          v[k] <= 1'b0;
        end
      end
      unique case ({in_xfer, out_xfer})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe (WIDTH=8, DEPTH=4): reset, streaming,
// backpressure, bubble collapse, flush and mid-stream async reset.
module tb_dff_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_cnt [9] = '{1, 2, 3, 4, 4, 3, 2, 1, 0};
  logic seen;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_data = 8'h00; out_ready = 1'b0;

    // 1: reset state
    step(); step();
    check("rst_ovalid", 32'(out_valid), 0);
    check("rst_odata",  32'(out_data),  0);
    check("rst_count",  32'(count),     0);
    check("rst_iready", 32'(in_ready),  1);
    rst = 1'b0;
    step();

    // 2: streaming, 3 edges from accept to presentation
    out_ready = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      in_valid = (t <= 5);
      in_data  = 8'(t);
      step();
      check($sformatf("s_ovalid%0d", t), 32'(out_valid),
            32'(t >= 4 && t <= 8));
      if (t >= 4 && t <= 8)
        check($sformatf("s_odata%0d", t), 32'(out_data), 32'(t - 3));
      check($sformatf("s_count%0d", t), 32'(count), 32'(exp_cnt[t-1]));
    end
    in_valid = 1'b0;

    // 3: backpressure fills the pipe, release drains in order
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(i);
      #1;
      check($sformatf("bp_iready%0d", i), 32'(in_ready), 1);
      step();
    end
    in_data = 8'hA4;
    #1;
    check("bp_full_iready", 32'(in_ready),  0);
    check("bp_full_count",  32'(count),     4);
    check("bp_full_ovalid", 32'(out_valid), 1);
    check("bp_full_odata",  32'(out_data),  32'hA0);
    step();
    check("bp_hold_odata",  32'(out_data),  32'hA0);
    check("bp_hold_count",  32'(count),     4);
    out_ready = 1'b1;
    #1;
    check("bp_rel_iready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    check("bp_swap_count", 32'(count), 4);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("bp_odata%0d", i), 32'(out_data), 32'hA0 + 32'(i));
      check($sformatf("bp_ovalid%0d", i), 32'(out_valid), 1);
      step();
    end
    check("bp_empty_count", 32'(count), 0);

    // 4: bubble collapse under stall
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11;
    step();
    in_valid = 1'b0;
    step(); step();
    in_valid = 1'b1; in_data = 8'h22;
    step();
    in_valid = 1'b0;
    step(); step();
    check("bc_count",  32'(count),     2);
    check("bc_odata1", 32'(out_data),  32'h11);
    check("bc_dut_v2", 32'(dut.v),     32'b1100);
    out_ready = 1'b1;
    step();
    check("bc_odata2",  32'(out_data),  32'h22);
    check("bc_ovalid2", 32'(out_valid), 1);
    step();
    check("bc_drained", 32'(out_valid), 0);
    check("bc_count0",  32'(count),     0);

    // 5: flush beats a simultaneous push
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h31 + 8'(i);
      step();
    end
    check("fl_count3", 32'(count), 3);
    flush = 1'b1; in_data = 8'h77;
    #1;
    check("fl_iready", 32'(in_ready),  0);
    check("fl_ovalid", 32'(out_valid), 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_count0", 32'(count),     0);
    check("fl_ovalid0", 32'(out_valid), 0);
    check("fl_odata",  32'(out_data),  0);
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen |= out_valid;
    end
    check("fl_no_emerge", 32'(seen), 0);

    // 6: async reset between edges while streaming
    for (int t = 1; t <= 3; t++) begin
      in_valid = 1'b1;
      in_data  = 8'(t);
      step();
    end
    check("ar_pre_count", 32'(count), 3);
    rst = 1'b1;
    #1;
    check("ar_ovalid", 32'(out_valid), 0);
    check("ar_count",  32'(count),     0);
    check("ar_iready", 32'(in_ready),  1);
    in_valid = 1'b0;
    #1;
    rst = 1'b0;
    step();
    in_valid = 1'b1; in_data = 8'h5A;
    step();
    in_valid = 1'b0;
    step(); step();
    check("ar_lat_early", 32'(out_valid), 0);
    step();
    check("ar_lat_ovalid", 32'(out_valid), 1);
    check("ar_lat_odata",  32'(out_data),  32'h5A);
    step();
    check("ar_lat_gone", 32'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
